pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 core.
- Drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four hazard types:
  - load-use hazards;
  - taken-branch redirects;
  - multi-cycle data-memory waits;
  - multi-cycle multiply/divide (MDU) waits.
- Hosts benchmark counters for cycles, stall cycles and redirects.

Parameters:
CNT_WIDTH, 32, width of each performance counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, synchronous, active-high
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  instruction in ID reads rs1
id_uses_rs2  in  1  instruction in ID reads rs2
ex_load  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_mdu_op  in  1  EX holds an MDU instruction (level, held while EX is frozen)
mdu_done  in  1  MDU result valid this cycle
mem_req  in  1  MEM holds a load or store
mem_ready  in  1  data memory completes the access this cycle
cnt_clear  in  1  synchronous clear of the counters
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (a flush wins over a deasserted enable in the target register)
cycle_cnt, stall_cnt, redirect_cnt  out  CNT_WIDTH each  performance counters

Behaviour:
- State register: RUN, MEM_WAIT, MDU_WAIT. Reset state is RUN.
- Control outputs are combinational from state and inputs, with zero latency. Only state and counters are registered.
- While rst=1:
  - all *_en = 0 and all *_flush = 0;
  - counters load 0 at the edge.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_load=1;
  - ex_rd != 0;
  - (id_uses_rs1 and id_rs1 == ex_rd) or (id_uses_rs2 and id_rs2 == ex_rd).
- Default in RUN: every enable is 1 and every flush is 0.
- RUN, priority highest first:
  1. mem_req and not mem_ready:
     - all five enables = 0, no flushes;
     - next state MEM_WAIT;
     - younger hazards are ignored this cycle and re-evaluated after release, because their stages are frozen.
  2. ex_mdu_op and not mdu_done:
     - pc_en = if_id_en = id_ex_en = ex_mem_en = 0;
     - ex_mem_flush = 1, mem_wb_en = 1 (older instructions drain);
     - next state MDU_WAIT.
  3. ex_branch_taken:
     - pc_en = 1 (redirect);
     - if_id_flush = 1, id_ex_flush = 1;
     - ex_mem_en = mem_wb_en = 1;
     - an lu condition in the same cycle is ignored (ID is wrong-path).
  4. lu:
     - pc_en = if_id_en = id_ex_en = 0;
     - id_ex_flush = 1;
     - ex_mem_en = mem_wb_en = 1;
     - exactly 1 bubble is inserted; the following cycle lu is false because the load has moved on.
- MEM_WAIT:
  - while mem_ready = 0: all enables 0;
  - when mem_ready = 1: default RUN outputs, next state RUN, and the RUN priority rules are re-applied from the next cycle.
- MDU_WAIT:
  - while mdu_done = 0: hold the MDU freeze pattern (ex_mem_flush = 1, mem_wb_en = 1);
  - when mdu_done = 1: all enables 1, no flush, next state RUN.
- ex_branch_taken and ex_mdu_op are mutually exclusive; the bench asserts this.
- Counters (all gated off during rst):
  - cycle_cnt increments every cycle when not in rst;
  - stall_cnt increments on every cycle with pc_en = 0;
  - redirect_cnt increments on every cycle where priority case 3 fires.
  - cnt_clear zeroes all counters at the edge and takes priority over increments in that cycle.
  - All counters wrap to 0 silently.
- Reset mid-wait: state returns to RUN at the next edge regardless of mem_ready or mdu_done.

Decomposition:
- Shared package (core_pkg):
  - state encodings ST_RUN = 2'd0, ST_MEM_WAIT = 2'd1, ST_MDU_WAIT = 2'd2;
  - REG_ADDR_W = 5.
- One combinational sub-module, load_use_detect, computes lu.
- Counters stay inline.

Test Plan:
- Load-use: lw x5 in EX with ex_rd = 5, ID uses rs1 = 5.
  - Exactly 1 cycle with pc_en = 0 and id_ex_flush = 1, then all enables 1.
  - stall_cnt += 1.
  - Repeat with ex_rd = 0: no stall.
- Branch with simultaneous lu: ex_branch_taken = 1 and lu true.
  - if_id_flush = id_ex_flush = 1 and pc_en = 1, with no stall.
  - redirect_cnt = 1.
- Memory wait: mem_req = 1 and mem_ready held 0 for 3 cycles, then 1.
  - All enables 0 for 3 cycles, then 1 on the ready cycle; state returns to RUN.
  - stall_cnt = 3.
- MDU wait with a concurrent memory wait: ex_mdu_op = 1 while mem_req = 1 and mem_ready = 0.
  - MEM_WAIT takes priority.
  - After mem_ready, MDU_WAIT holds ex_mem_flush = 1 until mdu_done, which arrives 4 cycles later.
- Reset mid-MDU_WAIT: assert rst for 1 cycle.
  - All outputs 0 during rst; state is RUN and counters are 0 afterwards.
- Counter wrap with CNT_WIDTH = 4: 16 cycles → cycle_cnt = 0. cnt_clear asserted during a stall cycle → stall_cnt = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core's pipeline control.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  // Enables of the PC and the four pipeline registers, oldest-to-youngest reversed.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pipe_en_t;

  // Bubble-insert requests; a flush overrides a deasserted enable.
  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } pipe_flush_t;

  localparam pipe_en_t    EN_ALL   = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
  localparam pipe_en_t    EN_NONE  = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
  // MDU freeze: everything up to EX holds, MEM/WB keeps draining.
  localparam pipe_en_t    EN_MDU   = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b1};
  // Load-use stall: front end holds, back end advances behind a bubble.
  localparam pipe_en_t    EN_LU    = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b1, mem_wb: 1'b1};
  localparam pipe_flush_t FL_NONE  = '{if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import core_pkg::*;
(
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  output logic                  lu
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency, so a load to x0 never stalls.
  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    lu      = ex_load && (ex_rd != REG_ADDR_W'(0)) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core plus cycle/stall/redirect counters.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_op,
  input  logic                  mdu_done,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  cnt_clear,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  redirect_cnt
);

  state_t      state;
  state_t      state_next;
  pipe_en_t    en;
  pipe_flush_t fl;
  logic        redirect;
  logic        lu;

  load_use_detect u_lu (
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (lu)
  );

  // State register; reset wins over any pending wait release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and zero-latency enable/flush decode, oldest hazard first.
  always_comb begin
    state_next = state;
    en         = EN_ALL;
    fl         = FL_NONE;
    redirect   = 1'b0;
    if (rst) begin
      en         = EN_NONE;
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            // Younger hazards are frozen in place and re-examined after release.
            en         = EN_NONE;
            state_next = ST_MEM_WAIT;
          end else if (ex_mdu_op && !mdu_done) begin
            en         = EN_MDU;
            fl.ex_mem  = 1'b1;
            state_next = ST_MDU_WAIT;
          end else if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use there is moot.
            fl.if_id   = 1'b1;
            fl.id_ex   = 1'b1;
            redirect   = 1'b1;
          end else if (lu) begin
            // One bubble suffices: next cycle the load has left EX.
            en         = EN_LU;
            fl.id_ex   = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_ready) begin
            en = EN_NONE;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_MDU_WAIT: begin
          if (!mdu_done) begin
            en        = EN_MDU;
            fl.ex_mem = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  assign pc_en        = en.pc;
  assign if_id_en     = en.if_id;
  assign id_ex_en     = en.id_ex;
  assign ex_mem_en    = en.ex_mem;
  assign mem_wb_en    = en.mem_wb;
  assign if_id_flush  = fl.if_id;
  assign id_ex_flush  = fl.id_ex;
  assign ex_mem_flush = fl.ex_mem;

  // Performance counters; clear beats increment, all wrap silently.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cycle_cnt    <= '0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (!en.pc) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (redirect) begin
        redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a spec-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int          CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_load = 1'b0;
  logic             ex_branch_taken = 1'b0, ex_mdu_op = 1'b0, mdu_done = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0, cnt_clear = 1'b0;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, redirect_cnt;

  pipeline_hazard_ctrl #(.CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_load(ex_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .cnt_clear(cnt_clear),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Expected response: {pc,if_id,id_ex,ex_mem,mem_wb} enables, {if_id,id_ex,ex_mem} flushes, counters.
  typedef struct packed {
    logic [4:0]       en;
    logic [2:0]       fl;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] rdr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passed = 0;

  // Reference model: pipeline is either flowing, stuck on memory, or stuck on the MDU.
  bit stuck_on_mem = 0;
  bit stuck_on_mdu = 0;
  int n_cycles = 0, n_stalls = 0, n_redirects = 0;

  task automatic check(input string tag, input string what, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s/%s: got %0h required %0h", tag, what, act, req);
  endtask

  // Predict this cycle's outputs from current inputs, queue them, then advance the model.
  task automatic step(input string tag);
    exp_t e;
    bit   dep, fire_redirect, next_mem, next_mdu;
    dep = ex_load && (ex_rd != 0) &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e.en = 5'b11111; e.fl = 3'b000;
    fire_redirect = 0; next_mem = 0; next_mdu = 0;
    if (rst) e.en = 5'b00000;
    else if (stuck_on_mem) begin
      if (!mem_ready) begin e.en = 5'b00000; next_mem = 1; end
    end else if (stuck_on_mdu) begin
      if (!mdu_done) begin e.en = 5'b00001; e.fl = 3'b001; next_mdu = 1; end
    end else if (mem_req && !mem_ready) begin
      e.en = 5'b00000; next_mem = 1;
    end else if (ex_mdu_op && !mdu_done) begin
      e.en = 5'b00001; e.fl = 3'b001; next_mdu = 1;
    end else if (ex_branch_taken) begin
      e.fl = 3'b110; fire_redirect = 1;
    end else if (dep) begin
      e.en = 5'b00011; e.fl = 3'b010;
    end
    e.cyc = CNT_W'(n_cycles); e.stl = CNT_W'(n_stalls); e.rdr = CNT_W'(n_redirects);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst || cnt_clear) begin
      n_cycles = 0; n_stalls = 0; n_redirects = 0;
    end else begin
      n_cycles    = (n_cycles + 1) % CMOD;
      n_stalls    = (n_stalls + (e.en[4] ? 0 : 1)) % CMOD;
      n_redirects = (n_redirects + (fire_redirect ? 1 : 0)) % CMOD;
    end
    stuck_on_mem = rst ? 0 : next_mem;
    stuck_on_mdu = rst ? 0 : next_mdu;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    rst = 0; cnt_clear = 0; ex_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_branch_taken = 0; ex_mdu_op = 0;
    mdu_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare against the queue head.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      assert (!(ex_branch_taken && ex_mdu_op)) else $error("FAIL excl: branch and mdu both set");
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, "en", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), int'(e.en));
        check(t, "flush", int'({if_id_flush, id_ex_flush, ex_mem_flush}), int'(e.fl));
        check(t, "cycle_cnt", int'(cycle_cnt), int'(e.cyc));
        check(t, "stall_cnt", int'(stall_cnt), int'(e.stl));
        check(t, "redirect_cnt", int'(redirect_cnt), int'(e.rdr));
      end
    end
  end

  initial begin
    int kind;
    repeat (2) @(posedge clk);
    #1;
    step("reset");

    // Load-use on rs1, then the load leaves, then a load to x0.
    idle_inputs(); step("idle");
    ex_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; step("lu");
    ex_load = 0; step("lu_after");
    ex_load = 1; ex_rd = 0; id_rs1 = 0; step("lu_x0");
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1; step("lu_rs2");
    idle_inputs(); step("idle2");

    // Taken branch with a simultaneous load-use.
    ex_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_branch_taken = 1; step("br_lu");
    idle_inputs(); step("after_br");

    // Memory wait of three cycles.
    mem_req = 1;
    repeat (3) step("mem_wait");
    mem_ready = 1; step("mem_ready");
    idle_inputs(); step("mem_after");

    // MDU op stuck behind a memory wait, then four cycles of MDU wait.
    mem_req = 1; ex_mdu_op = 1;
    repeat (2) step("mdu_mem_wait");
    mem_ready = 1; step("mdu_mem_ready");
    mem_req = 0; mem_ready = 0;
    repeat (4) step("mdu_wait");
    mdu_done = 1; step("mdu_done");
    idle_inputs(); step("mdu_after");

    // Reset in the middle of an MDU wait.
    ex_mdu_op = 1;
    repeat (2) step("mdu_pre_rst");
    rst = 1; step("rst_mid");
    idle_inputs(); step("post_rst");

    // Counter clear during a stall cycle.
    mem_req = 1; step("clr_stall0");
    cnt_clear = 1; step("clr_stall1");
    cnt_clear = 0; mem_ready = 1; step("clr_release");
    idle_inputs();
    repeat (18) step("wrap");

    // Randomized traffic, keeping branch and MDU exclusive.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      cnt_clear   = ($urandom_range(0, 15) == 0);
      ex_load     = $urandom_range(0, 1);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_uses_rs1 = $urandom_range(0, 1);
      id_uses_rs2 = $urandom_range(0, 1);
      kind        = $urandom_range(0, 3);
      ex_branch_taken = (kind == 1);
      ex_mdu_op   = (kind == 2) || (stuck_on_mdu && !ex_branch_taken);
      mdu_done    = ($urandom_range(0, 3) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_ready   = ($urandom_range(0, 1) == 0);
      step("rand");
    end
    idle_inputs();
    step("final");

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    check("drain", "queue_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
